// File: rtl/bsg_nasti_mem_model_if.sv
// NASTI (AXI4) slave-side bundle for bsg_nasti_mem_model: AW/W/B/AR/R channels.
// Signal names keep the _i/_o suffix as seen from the memory model.
interface bsg_nasti_mem_model_if #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 64,
    parameter int id_width_p   = 6
);
    logic                      aw_valid_i, aw_ready_o;
    logic [addr_width_p-1:0]   aw_addr_i;
    logic [7:0]                aw_len_i;
    logic [2:0]                aw_size_i;
    logic [1:0]                aw_burst_i;
    logic [id_width_p-1:0]     aw_id_i;
    logic                      w_valid_i, w_ready_o, w_last_i;
    logic [data_width_p-1:0]   w_data_i;
    logic [data_width_p/8-1:0] w_strb_i;
    logic                      b_valid_o, b_ready_i;
    logic [1:0]                b_resp_o;
    logic [id_width_p-1:0]     b_id_o;
    logic                      ar_valid_i, ar_ready_o;
    logic [addr_width_p-1:0]   ar_addr_i;
    logic [7:0]                ar_len_i;
    logic [2:0]                ar_size_i;
    logic [1:0]                ar_burst_i;
    logic [id_width_p-1:0]     ar_id_i;
    logic                      r_valid_o, r_ready_i, r_last_o;
    logic [data_width_p-1:0]   r_data_o;
    logic [1:0]                r_resp_o;
    logic [id_width_p-1:0]     r_id_o;

    modport slave (
        input  aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_id_i,
        input  w_valid_i, w_data_i, w_strb_i, w_last_i, b_ready_i,
        input  ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i, r_ready_i,
        output aw_ready_o, w_ready_o, b_valid_o, b_resp_o, b_id_o,
        output ar_ready_o, r_valid_o, r_data_o, r_resp_o, r_last_o, r_id_o
    );
    modport master (
        output aw_valid_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_id_i,
        output w_valid_i, w_data_i, w_strb_i, w_last_i, b_ready_i,
        output ar_valid_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_id_i, r_ready_i,
        input  aw_ready_o, w_ready_o, b_valid_o, b_resp_o, b_id_o,
        input  ar_ready_o, r_valid_o, r_data_o, r_resp_o, r_last_o, r_id_o
    );
endinterface

// File: rtl/bsg_nasti_mem_model.sv
// Behavioural NASTI slave memory: independent single-outstanding write and read burst engines
// over a word array with byte-enable writes and combinational read data.
module bsg_nasti_mem_model #(
    parameter int                    addr_width_p   = 32,
    parameter int                    data_width_p   = 64,
    parameter int                    id_width_p     = 6,
    parameter int                    mem_els_p      = 4096,
    parameter logic [addr_width_p-1:0] base_addr_p  = '0,
    parameter int                    read_latency_p = 2
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_nasti_mem_model_if.slave io
);
    localparam int BYTES = data_width_p / 8;
    localparam int LG_B  = $clog2(BYTES);
    localparam int IDX_W = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
    localparam logic [addr_width_p-1:0] ELS = addr_width_p'(mem_els_p);
    localparam logic [addr_width_p-1:0] STEP = addr_width_p'(BYTES);
    localparam logic [2:0] SIZE_OK = 3'(LG_B);
    localparam logic [3:0] LAT_INIT = 4'((read_latency_p >= 2) ? read_latency_p - 2 : 0);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    logic [data_width_p-1:0] mem_r [mem_els_p];

    w_state_e                w_state_q, w_state_d;
    logic [addr_width_p-1:0] w_addr_q, w_addr_d;
    logic [7:0]              w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]              w_size_q, w_size_d;
    logic [1:0]              w_burst_q, w_burst_d;
    logic [id_width_p-1:0]   w_id_q, w_id_d;
    logic                    w_dec_q, w_dec_d, w_slv_q, w_slv_d;

    r_state_e                r_state_q, r_state_d;
    logic [addr_width_p-1:0] r_addr_q, r_addr_d;
    logic [7:0]              r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]              r_size_q, r_size_d;
    logic [1:0]              r_burst_q, r_burst_d;
    logic [id_width_p-1:0]   r_id_q, r_id_d;
    logic [3:0]              r_lat_q, r_lat_d;

    logic [addr_width_p-1:0] w_off, w_word, r_off, r_word;
    logic                    w_in_range, r_in_range, w_last_beat, mem_we;
    logic [IDX_W-1:0]        w_idx, r_idx;

    // A beat is out of range if below base or its word index falls past the array end.
    assign w_off       = w_addr_q - base_addr_p;
    assign w_word      = w_off >> LG_B;
    assign w_in_range  = (w_addr_q >= base_addr_p) && (w_word < ELS);
    assign w_idx       = w_word[IDX_W-1:0];
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign r_off       = r_addr_q - base_addr_p;
    assign r_word      = r_off >> LG_B;
    assign r_in_range  = (r_addr_q >= base_addr_p) && (r_word < ELS);
    assign r_idx       = r_word[IDX_W-1:0];

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_id_d    = w_id_q;
        w_cnt_d   = w_cnt_q;
        w_dec_d   = w_dec_q;
        w_slv_d   = w_slv_q;
        mem_we    = 1'b0;
        unique case (w_state_q)
            W_IDLE: if (io.aw_valid_i) begin
                w_addr_d  = io.aw_addr_i;
                w_len_d   = io.aw_len_i;
                w_size_d  = io.aw_size_i;
                w_burst_d = io.aw_burst_i;
                w_id_d    = io.aw_id_i;
                w_cnt_d   = 8'd0;
                w_dec_d   = 1'b0;
                w_slv_d   = (io.aw_size_i != SIZE_OK);
                w_state_d = W_DATA;
            end
            W_DATA: if (io.w_valid_i) begin
                mem_we = w_in_range;
                if (!w_in_range) w_dec_d = 1'b1;
                if (io.w_last_i != w_last_beat) w_slv_d = 1'b1;
                if (w_burst_q != 2'b00) w_addr_d = w_addr_q + STEP;
                if (w_last_beat) w_state_d = W_RESP;
                else             w_cnt_d   = w_cnt_q + 8'd1;
            end
            W_RESP: if (io.b_ready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_id_q    <= '0;
            w_cnt_q   <= '0;
            w_dec_q   <= 1'b0;
            w_slv_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_id_q    <= w_id_d;
            w_cnt_q   <= w_cnt_d;
            w_dec_q   <= w_dec_d;
            w_slv_q   <= w_slv_d;
        end
    end

    // Array has no reset; the read port below sees the pre-write value in a colliding cycle.
    always_ff @(posedge clk_i) begin
        if (mem_we)
            for (int b = 0; b < BYTES; b++)
                if (io.w_strb_i[b]) mem_r[w_idx][8*b +: 8] <= io.w_data_i[8*b +: 8];
    end

    assign io.aw_ready_o = (w_state_q == W_IDLE);
    assign io.w_ready_o  = (w_state_q == W_DATA);
    assign io.b_valid_o  = (w_state_q == W_RESP);
    assign io.b_resp_o   = !io.b_valid_o ? 2'b00 : w_dec_q ? 2'b11 : w_slv_q ? 2'b10 : 2'b00;
    assign io.b_id_o     = io.b_valid_o ? w_id_q : '0;

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_id_d    = r_id_q;
        r_cnt_d   = r_cnt_q;
        r_lat_d   = r_lat_q;
        unique case (r_state_q)
            R_IDLE: if (io.ar_valid_i) begin
                r_addr_d  = io.ar_addr_i;
                r_len_d   = io.ar_len_i;
                r_size_d  = io.ar_size_i;
                r_burst_d = io.ar_burst_i;
                r_id_d    = io.ar_id_i;
                r_cnt_d   = 8'd0;
                r_lat_d   = LAT_INIT;
                r_state_d = (read_latency_p <= 1) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (r_lat_q == 4'd0) r_state_d = R_DATA;
                else                 r_lat_d   = r_lat_q - 4'd1;
            end
            R_DATA: if (io.r_ready_i) begin
                if (r_burst_q != 2'b00) r_addr_d = r_addr_q + STEP;
                if (r_cnt_q == r_len_q) r_state_d = R_IDLE;
                else                    r_cnt_d   = r_cnt_q + 8'd1;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_cnt_q   <= '0;
            r_lat_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_id_q    <= r_id_d;
            r_cnt_q   <= r_cnt_d;
            r_lat_q   <= r_lat_d;
        end
    end

    assign io.ar_ready_o = (r_state_q == R_IDLE);
    assign io.r_valid_o  = (r_state_q == R_DATA);
    assign io.r_data_o   = (io.r_valid_o && r_in_range) ? mem_r[r_idx] : '0;
    assign io.r_resp_o   = !io.r_valid_o ? 2'b00 : !r_in_range ? 2'b11 :
                           (r_size_q != SIZE_OK) ? 2'b10 : 2'b00;
    assign io.r_last_o   = io.r_valid_o && (r_cnt_q == r_len_q);
    assign io.r_id_o     = io.r_valid_o ? r_id_q : '0;
endmodule

// File: tb/tb_bsg_nasti_mem_model.sv
// Scoreboard bench for bsg_nasti_mem_model: a word-level reference memory predicts B/R responses,
// a monitor compares them on every handshake; directed boundary cases plus random bursts.
module tb_bsg_nasti_mem_model;
    localparam int AW = 32, DW = 64, IDW = 6, ELS = 4096, LAT = 2;
    localparam logic [31:0] BASE = 32'h0;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bsg_nasti_mem_model_if #(.addr_width_p(AW), .data_width_p(DW), .id_width_p(IDW)) io ();
    bsg_nasti_mem_model #(.addr_width_p(AW), .data_width_p(DW), .id_width_p(IDW),
        .mem_els_p(ELS), .base_addr_p(BASE), .read_latency_p(LAT)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .io(io));

    typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [IDW-1:0] id; } r_exp_t;
    b_exp_t     b_q[$];
    r_exp_t     r_q[$];
    logic [63:0] mdl [int];
    logic [63:0] wdat_q[$];
    logic [7:0]  wstrb_q[$];
    int n_vec = 0, n_err = 0;
    bit hold_r = 1'b0;

    function automatic void check(string nm, logic [127:0] got, logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endfunction

    function automatic bit in_rng(logic [31:0] a);
        return (a >= BASE) && (((a - BASE) >> 3) < 32'(ELS));
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    // Monitor: compare every B and R handshake against the queued predictions.
    always @(negedge clk) begin : mon
        b_exp_t be;
        r_exp_t re;
        if (rst_n) begin
            if (io.b_valid_o && io.b_ready_i) begin
                if (b_q.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    be = b_q.pop_front();
                    check("b_id", io.b_id_o, be.id);
                    check("b_resp", io.b_resp_o, be.resp);
                end
            end
            if (io.r_valid_o && io.r_ready_i) begin
                if (r_q.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    re = r_q.pop_front();
                    check("r_data", io.r_data_o, re.data);
                    check("r_resp_last_id", {io.r_resp_o, io.r_last_o, io.r_id_o},
                          {re.resp, re.last, re.id});
                end
            end
        end
    end

    initial begin
        io.b_ready_i = 1'b0;
        io.r_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            io.b_ready_i = ($urandom_range(3) != 0);
            io.r_ready_i = !hold_r && ($urandom_range(3) != 0);
        end
    end

    task automatic timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s_timeout waited=bound required=handshake @%0t", nm, $time);
    endtask

    task automatic wait_rdy(input int which, input string nm);
        bit got = 1'b0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            case (which)
                0:       got = io.aw_ready_o;
                1:       got = io.w_ready_o;
                default: got = io.ar_ready_o;
            endcase
        end
        if (!got) timeout(nm);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [IDW-1:0] id,
                            input int bad_last = -1, input int abort_at = -1);
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  s;
        logic        wl;
        bit          dec = 1'b0, slv;
        b_exp_t      be;
        slv = (size != 3'd3);
        io.aw_addr_i = addr; io.aw_len_i = len; io.aw_size_i = size;
        io.aw_burst_i = burst; io.aw_id_i = id; io.aw_valid_i = 1'b1;
        wait_rdy(0, "aw");
        io.aw_valid_i = 1'b0;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            d  = (wdat_q.size() != 0) ? wdat_q.pop_front() : {$urandom, $urandom};
            s  = (wstrb_q.size() != 0) ? wstrb_q.pop_front()
                 : ($urandom_range(1) != 0 ? 8'hFF : 8'($urandom));
            wl = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
            if ($urandom_range(3) == 0) begin @(posedge clk); #1; end
            io.w_data_i = d; io.w_strb_i = s; io.w_last_i = wl; io.w_valid_i = 1'b1;
            if (i == abort_at) return;
            wait_rdy(1, "w");
            io.w_valid_i = 1'b0;
            if (in_rng(a)) begin
                for (int b = 0; b < 8; b++) if (s[b]) mdl[widx(a)][8*b +: 8] = d[8*b +: 8];
            end else dec = 1'b1;
            if (wl != (i == int'(len))) slv = 1'b1;
            if (burst != 2'b00) a = a + 32'd8;
        end
        be.id = id;
        be.resp = dec ? 2'd3 : slv ? 2'd2 : 2'd0;
        b_q.push_back(be);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [IDW-1:0] id);
        logic [31:0] a = addr;
        r_exp_t re;
        for (int i = 0; i <= int'(len); i++) begin
            re.id = id;
            re.last = (i == int'(len));
            if (in_rng(a)) begin
                re.data = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'h0;
                re.resp = (size != 3'd3) ? 2'd2 : 2'd0;
            end else begin
                re.data = 64'h0;
                re.resp = 2'd3;
            end
            r_q.push_back(re);
            if (burst != 2'b00) a = a + 32'd8;
        end
        io.ar_addr_i = addr; io.ar_len_i = len; io.ar_size_i = size;
        io.ar_burst_i = burst; io.ar_id_i = id; io.ar_valid_i = 1'b1;
        wait_rdy(2, "ar");
        io.ar_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && (b_q.size() != 0 || r_q.size() != 0); t++) @(posedge clk);
        #1;
        if (b_q.size() != 0 || r_q.size() != 0) begin
            timeout("drain");
            b_q.delete();
            r_q.delete();
        end
    endtask

    task automatic check_reset(input string nm);
        check(nm, {io.aw_ready_o, io.ar_ready_o, io.w_ready_o, io.b_valid_o, io.r_valid_o,
                   io.r_last_o, io.b_resp_o, io.r_resp_o, io.b_id_o, io.r_id_o, io.r_data_o},
                  {1'b1, 1'b1, 4'b0, 2'b0, 2'b0, 6'b0, 6'b0, 64'b0});
    endtask

    task automatic fill_strb(input int n);
        repeat (n) wstrb_q.push_back(8'hFF);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int hs, lat;
        logic [IDW+66:0] snap;
        logic [31:0] addr;
        logic [7:0] len;
        io.aw_valid_i = 0; io.aw_addr_i = 0; io.aw_len_i = 0; io.aw_size_i = 0;
        io.aw_burst_i = 0; io.aw_id_i = 0; io.w_valid_i = 0; io.w_data_i = 0;
        io.w_strb_i = 0; io.w_last_i = 0; io.ar_valid_i = 0; io.ar_addr_i = 0;
        io.ar_len_i = 0; io.ar_size_i = 0; io.ar_burst_i = 0; io.ar_id_i = 0;
        #12 check_reset("reset_state");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload the regions that later reads touch.
        fill_strb(64); do_write(32'h0,   8'd63, 3'd3, 2'b01, 6'd1); drain();
        fill_strb(64); do_write(32'h200, 8'd63, 3'd3, 2'b01, 6'd1); drain();
        fill_strb(8);  do_write(32'((ELS - 8) * 8), 8'd7, 3'd3, 2'b01, 6'd1); drain();

        // Basic INCR write then read back.
        wdat_q = '{64'h11, 64'h22, 64'h33, 64'h44}; fill_strb(4);
        do_write(32'h100, 8'd3, 3'd3, 2'b01, 6'd5); drain();
        do_read(32'h100, 8'd3, 3'd3, 2'b01, 6'd5); drain();

        // Partial strobe over a zeroed word.
        wdat_q = '{64'h0}; fill_strb(1);
        do_write(32'hF0, 8'd0, 3'd3, 2'b01, 6'd2); drain();
        wdat_q = '{64'hFFFF_FFFF_FFFF_FFFF}; wstrb_q = '{8'h0F};
        do_write(32'hF0, 8'd0, 3'd3, 2'b01, 6'd2); drain();
        do_read(32'hF0, 8'd0, 3'd3, 2'b01, 6'd2); drain();

        // Read latency and output stability under back-pressure.
        hold_r = 1'b1;
        @(posedge clk); #1;
        do_read(32'hF0, 8'd0, 3'd3, 2'b01, 6'd9);
        hs = cyc - 1;
        lat = -1;
        for (int t = 0; t < 20 && lat < 0; t++) begin
            @(negedge clk);
            if (io.r_valid_o) lat = cyc - hs;
        end
        check("rd_latency", 32'(lat), 32'(LAT));
        snap = {io.r_data_o, io.r_id_o, io.r_last_o, io.r_resp_o};
        repeat (5) begin
            @(negedge clk);
            check("rd_stable", {io.r_valid_o, io.r_data_o, io.r_id_o, io.r_last_o, io.r_resp_o},
                  {1'b1, snap});
        end
        hold_r = 1'b0;
        drain();

        // Out of range: DECERR, word 0 must not alias.
        do_write(32'(BASE + ELS * 8), 8'd0, 3'd3, 2'b01, 6'd3); drain();
        do_read(32'(BASE + ELS * 8), 8'd0, 3'd3, 2'b01, 6'd3);
        do_read(32'h0, 8'd0, 3'd3, 2'b01, 6'd3); drain();

        // Early w_last gives SLVERR after full length; FIXED burst keeps the last beat.
        do_write(32'h200, 8'd3, 3'd3, 2'b01, 6'd7, 1); drain();
        do_read(32'h200, 8'd3, 3'd3, 2'b01, 6'd7); drain();
        wdat_q = '{64'hA, 64'hB, 64'hC}; fill_strb(3);
        do_write(32'h208, 8'd2, 3'd3, 2'b00, 6'd8); drain();
        do_read(32'h208, 8'd0, 3'd3, 2'b01, 6'd8); drain();

        // Illegal size, top-of-array crossing, address wrap.
        do_write(32'h40, 8'd1, 3'd2, 2'b01, 6'd4); drain();
        do_read(32'h40, 8'd1, 3'd2, 2'b01, 6'd4); drain();
        do_write(32'((ELS - 2) * 8), 8'd3, 3'd3, 2'b01, 6'd6); drain();
        do_read(32'((ELS - 2) * 8), 8'd3, 3'd3, 2'b01, 6'd6); drain();
        do_write(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 6'd10); drain();
        do_read(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 6'd10); drain();

        // 256-beat burst.
        fill_strb(256);
        do_write(32'(100 * 8), 8'd255, 3'd3, 2'b01, 6'd12); drain();
        do_read(32'(100 * 8), 8'd255, 3'd3, 2'b01, 6'd12); drain();

        // Same-cycle AW and AR on disjoint words.
        fork
            do_write(32'(10 * 8), 8'd3, 3'd3, 2'b01, 6'd11);
            do_read(32'(40 * 8), 8'd3, 3'd3, 2'b01, 6'd13);
        join
        drain();

        // Random bursts.
        for (int k = 0; k < 40; k++) begin
            addr = ($urandom_range(1) != 0) ? 32'(BASE + $urandom_range(63) * 8)
                                            : 32'(BASE + (ELS - 4 + $urandom_range(5)) * 8);
            len  = 8'($urandom_range(7));
            if ($urandom_range(1) != 0)
                do_write(addr, len, ($urandom_range(7) == 0) ? 3'd2 : 3'd3, 2'($urandom_range(3)),
                         6'($urandom), ($urandom_range(7) == 0) ? $urandom_range(int'(len)) : -1);
            else
                do_read(addr, len, ($urandom_range(7) == 0) ? 3'd2 : 3'd3, 2'($urandom_range(3)),
                        6'($urandom));
            drain();
        end

        // Reset during the second write beat.
        do_write(32'(96 * 8), 8'd3, 3'd3, 2'b01, 6'd14, -1, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("reset_mid_write");
        io.w_valid_i = 1'b0;
        b_q.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_write(32'(96 * 8), 8'd1, 3'd3, 2'b01, 6'd15); drain();
        do_read(32'(96 * 8), 8'd1, 3'd3, 2'b01, 6'd15); drain();

        // Reset while a read beat is being presented.
        hold_r = 1'b1;
        @(posedge clk); #1;
        do_read(32'(96 * 8), 8'd3, 3'd3, 2'b01, 6'd16);
        for (int t = 0; t < 20 && !io.r_valid_o; t++) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset("reset_mid_read");
        r_q.delete();
        hold_r = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_write(32'(97 * 8), 8'd0, 3'd3, 2'b01, 6'd17); drain();
        do_read(32'(96 * 8), 8'd3, 3'd3, 2'b01, 6'd18); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
